sdram_scanout_reader: RTL and testbench

Avalon-MM burst read master that drives the HPS FPGA-to-SDRAM port 0 (64-bit, 29-bit word address, 8-bit burstcount) to fetch one frame of pixel data per request. It streams the frame into a local FIFO and presents it on a valid/ready stream to the video scanout logic. The FIFO is credit-managed, so the block never issues a read it cannot absorb. The write half of the port is tied idle.

---
 rtl/scanout_pkg.sv | 8 +
 rtl/scanout_fifo.sv | 59 +++++
 rtl/sdram_scanout_reader.sv | 158 +++++++++++++++
 tb/tb_sdram_scanout_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
// Shared widths and FSM state type for the SDRAM scanout reader.
package scanout_pkg;
   localparam int AVM_ADDR_W  = 29;
   localparam int AVM_DATA_W  = 64;
   localparam int AVM_BURST_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/scanout_fifo.sv
// Synchronous show-ahead FIFO: the head word is presented combinationally while not empty.
module scanout_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 256,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_fire;
   logic             pop_fire;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem[rd_ptr_q];

   // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
   assign pop_fire  = pop && !empty;
   assign push_fire = push && (!full || pop_fire);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_fire && !pop_fire) count_d = count_q + CNT_W'(1);
      if (pop_fire && !push_fire) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem[wr_ptr_q] <= wdata;
   end
endmodule

// File: rtl/sdram_scanout_reader.sv
// Avalon-MM burst read master that fetches one frame into a credit-managed FIFO
// and streams it out to scanout.
module sdram_scanout_reader
   import scanout_pkg::*;
#(
   parameter int BURST_LEN   = 16,
   parameter int FIFO_DEPTH  = 256,
   parameter int FRAME_WORDS = 192000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   frame_start,
   input  logic [AVM_ADDR_W-1:0]  base_addr,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overflow,
   output logic [AVM_ADDR_W-1:0]  avm_address,
   output logic [AVM_BURST_W-1:0] avm_burstcount,
   output logic                   avm_read,
   input  logic                   avm_waitrequest,
   input  logic [AVM_DATA_W-1:0]  avm_readdata,
   input  logic                   avm_readdatavalid,
   output logic                   avm_write,
   output logic [AVM_DATA_W-1:0]  avm_writedata,
   output logic [7:0]             avm_byteenable,
   output logic [AVM_DATA_W-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int REM_W = $clog2(FRAME_WORDS + 1);

   state_e                 state_q, state_d;
   logic                   avm_read_q, avm_read_d;
   logic [AVM_ADDR_W-1:0]  avm_address_q, avm_address_d;
   logic [AVM_BURST_W-1:0] avm_burstcount_q, avm_burstcount_d;
   logic [AVM_ADDR_W-1:0]  next_addr_q, next_addr_d;
   logic [REM_W-1:0]       remaining_q, remaining_d;
   logic [CNT_W-1:0]       pending_q, pending_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic                   overflow_q, overflow_d;

   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   rdv_take;
   logic                   pop_fire;
   logic                   accept;
   logic [AVM_BURST_W-1:0] burst_next;
   int                     free;

   // Data is only expected while words are owed; stale beats after a reset are dropped here.
   assign rdv_take = avm_readdatavalid && (pending_q != '0);
   assign pop_fire = out_valid && out_ready;
   assign accept   = avm_read_q && !avm_waitrequest;
   assign free     = FIFO_DEPTH - int'(fifo_count) - int'(pending_q);
   assign burst_next = (int'(remaining_q) >= BURST_LEN) ? AVM_BURST_W'(BURST_LEN)
                                                        : AVM_BURST_W'(remaining_q);

   scanout_fifo #(.WIDTH(AVM_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (rdv_take),
      .wdata (avm_readdata),
      .pop   (out_ready),
      .rdata (out_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d          = state_q;
      avm_read_d       = avm_read_q;
      avm_address_d    = avm_address_q;
      avm_burstcount_d = avm_burstcount_q;
      next_addr_d      = next_addr_q;
      remaining_d      = remaining_q;
      busy_d           = busy_q;
      frame_done_d     = 1'b0;
      overflow_d       = overflow_q | (rdv_take && fifo_full && !pop_fire);
      pending_d        = pending_q;
      if (accept)   pending_d = pending_d + CNT_W'(avm_burstcount_q);
      if (rdv_take) pending_d = pending_d - CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               next_addr_d = base_addr;
               remaining_d = REM_W'(FRAME_WORDS);
               pending_d   = '0;
               busy_d      = 1'b1;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (avm_read_q) begin
               if (!avm_waitrequest) begin
                  avm_read_d  = 1'b0;
                  next_addr_d = next_addr_q + AVM_ADDR_W'(avm_burstcount_q);
                  remaining_d = remaining_q - REM_W'(avm_burstcount_q);
                  if (remaining_q == REM_W'(avm_burstcount_q)) state_d = DRAIN;
               end
            end else if (remaining_q != '0 && free >= BURST_LEN) begin
               avm_read_d       = 1'b1;
               avm_address_d    = next_addr_q;
               avm_burstcount_d = burst_next;
            end
         end
         DRAIN: begin
            if (pending_d == '0) begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         avm_read_q       <= 1'b0;
         avm_address_q    <= '0;
         avm_burstcount_q <= '0;
         next_addr_q      <= '0;
         remaining_q      <= '0;
         pending_q        <= '0;
         busy_q           <= 1'b0;
         frame_done_q     <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         avm_read_q       <= avm_read_d;
         avm_address_q    <= avm_address_d;
         avm_burstcount_q <= avm_burstcount_d;
         next_addr_q      <= next_addr_d;
         remaining_q      <= remaining_d;
         pending_q        <= pending_d;
         busy_q           <= busy_d;
         frame_done_q     <= frame_done_d;
         overflow_q       <= overflow_d;
      end
   end

   assign avm_read       = avm_read_q;
   assign avm_address    = avm_address_q;
   assign avm_burstcount = avm_burstcount_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign overflow       = overflow_q;
   assign out_valid      = !fifo_empty;
   assign avm_write      = 1'b0;
   assign avm_writedata  = '0;
   assign avm_byteenable = 8'hFF;
endmodule

// File: tb/tb_sdram_scanout_reader.sv
// Directed-plus-random bench for sdram_scanout_reader with a queue-based slave and frame model.
module tb_sdram_scanout_reader;
   localparam int FW    = 40;
   localparam int BL    = 16;
   localparam int DEPTH = 32;

   logic        clk;
   logic        reset_n;
   logic        frame_start;
   logic [28:0] base_addr;
   logic        busy;
   logic        frame_done;
   logic        overflow;
   logic [28:0] avm_address;
   logic [7:0]  avm_burstcount;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [63:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        avm_write;
   logic [63:0] avm_writedata;
   logic [7:0]  avm_byteenable;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_q[$];
   logic [36:0] cmd_exp[$];
   logic [28:0] resp_q[$];
   int delivered = 0;
   int accepts   = 0;
   int pulses    = 0;
   bit frame_active = 0;
   bit done_expect  = 0;
   bit rsp_en       = 1;
   int wr_mode      = 0;
   int rdy_mode     = 1;

   sdram_scanout_reader #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .frame_start       (frame_start),
      .base_addr         (base_addr),
      .busy              (busy),
      .frame_done        (frame_done),
      .overflow          (overflow),
      .avm_address       (avm_address),
      .avm_burstcount    (avm_burstcount),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] word_of(input logic [28:0] a);
      return {3'b101, a, a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_read"},       {63'd0, avm_read}, 64'd0);
      check({tag, "_addr"},       {35'd0, avm_address}, 64'd0);
      check({tag, "_bcount"},     {56'd0, avm_burstcount}, 64'd0);
      check({tag, "_busy"},       {63'd0, busy}, 64'd0);
      check({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
      check({tag, "_overflow"},   {63'd0, overflow}, 64'd0);
      check({tag, "_out_valid"},  {63'd0, out_valid}, 64'd0);
      check({tag, "_write"},      {63'd0, avm_write}, 64'd0);
      check({tag, "_wdata"},      avm_writedata, 64'd0);
      check({tag, "_byteen"},     {56'd0, avm_byteenable}, 64'hFF);
   endtask

   // Frame model: expected word stream and burst list from base, length and burst size.
   task automatic start_frame(input logic [28:0] base);
      logic [28:0] a;
      int rem;
      int bc;
      exp_q.delete();
      cmd_exp.delete();
      delivered = 0;
      accepts = 0;
      pulses = 0;
      done_expect = 0;
      frame_active = 1;
      for (int i = 0; i < FW; i++) exp_q.push_back(word_of(base + 29'(i)));
      a = base;
      rem = FW;
      while (rem > 0) begin
         bc = (rem < BL) ? rem : BL;
         cmd_exp.push_back({a, 8'(bc)});
         a = a + 29'(bc);
         rem -= bc;
      end
      frame_start = 1'b1;
      base_addr = base;
      @(posedge clk); #1;
      frame_start = 1'b0;
      base_addr = 29'($urandom);
      check("busy_set", {63'd0, busy}, 64'd1);
   endtask

   task automatic finish_frame(input string tag, input int ncmds);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done_timeout"}, {63'd0, busy}, 64'd0);
      rdy_mode = 1;
      repeat (60) @(posedge clk);
      #1;
      check({tag, "_pulses"},    64'(pulses), 64'd1);
      check({tag, "_accepts"},   64'(accepts), 64'(ncmds));
      check({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_cmds_left"}, 64'(cmd_exp.size()), 64'd0);
      check({tag, "_overflow"},  {63'd0, overflow}, 64'd0);
      check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      frame_active = 0;
   endtask

   // Slave, consumer and stream monitor; all driving and sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (done_expect) begin
            check("frame_done_timing", {63'd0, frame_done}, 64'd1);
            check("busy_clear", {63'd0, busy}, 64'd0);
            done_expect = 0;
         end
         if (frame_done === 1'b1) pulses++;

         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
         endcase
         if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) check("spurious_word", {63'd0, out_valid}, 64'd0);
            else check("word", out_data, exp_q.pop_front());
         end

         if (rsp_en && resp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = word_of(resp_q.pop_front());
            delivered++;
            if (frame_active && delivered == FW) done_expect = 1;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = {$urandom, $urandom};
         end

         case (wr_mode)
            0:       avm_waitrequest = 1'b0;
            1:       avm_waitrequest = 1'b1;
            default: avm_waitrequest = ($urandom_range(0, 3) == 0);
         endcase
         if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
            accepts++;
            if (cmd_exp.size() == 0) check("spurious_cmd", {63'd0, avm_read}, 64'd0);
            else check("cmd", {27'd0, avm_address, avm_burstcount}, {27'd0, cmd_exp.pop_front()});
            for (int j = 0; j < int'(avm_burstcount); j++) resp_q.push_back(avm_address + 29'(j));
         end
      end
   end

   initial begin
      logic [28:0] cap_addr;
      logic [7:0]  cap_bc;
      int          acc0;
      int          n;

      reset_n = 1'b0;
      frame_start = 1'b0;
      base_addr = '0;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
      avm_readdatavalid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle("after_reset");

      // Basic frame: three bursts, last one short.
      wr_mode = 0; rdy_mode = 1;
      start_frame(29'h100);
      finish_frame("basic", 3);

      // Consumer stalled: credit allows exactly two bursts.
      rdy_mode = 0;
      start_frame(29'h2000);
      rdy_mode = 0;
      repeat (200) @(posedge clk);
      #1;
      check("stall_accepts", 64'(accepts), 64'd2);
      check("stall_read_low", {63'd0, avm_read}, 64'd0);
      check("stall_fifo_full", {63'd0, out_valid}, 64'd1);
      check("stall_busy", {63'd0, busy}, 64'd1);
      rdy_mode = 2;
      finish_frame("stall", 3);

      // Waitrequest held for 5 cycles on the first command.
      wr_mode = 0; rdy_mode = 1;
      start_frame(29'h3000);
      n = 0;
      while (avm_read !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("wr_read_seen", {63'd0, avm_read}, 64'd1);
      wr_mode = 1;
      cap_addr = avm_address;
      cap_bc = avm_burstcount;
      acc0 = accepts;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("wr_hold_addr", {35'd0, avm_address}, {35'd0, cap_addr});
         check("wr_hold_bc", {56'd0, avm_burstcount}, {56'd0, cap_bc});
         check("wr_hold_read", {63'd0, avm_read}, 64'd1);
         check("wr_hold_acc", 64'(accepts), 64'(acc0));
      end
      wr_mode = 0;
      @(posedge clk); #1;
      check("wr_one_accept", 64'(accepts), 64'(acc0 + 1));
      check("wr_read_drop", {63'd0, avm_read}, 64'd0);
      finish_frame("waitreq", 3);

      // Address wrap, with a second frame_start while busy that must be ignored.
      wr_mode = 2; rdy_mode = 2;
      start_frame(29'h1FFF_FFF0);
      repeat (3) @(posedge clk);
      #1;
      frame_start = 1'b1;
      base_addr = 29'h0ABC;
      @(posedge clk); #1;
      frame_start = 1'b0;
      finish_frame("wrap", 3);

      // Reset mid-burst with read data still in flight.
      wr_mode = 0; rdy_mode = 1; rsp_en = 0;
      start_frame(29'h4000);
      n = 0;
      while (accepts < 1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_cmd_seen", {63'd0, accepts >= 1}, 64'd1);
      frame_active = 0;
      done_expect = 0;
      reset_n = 1'b0;
      #1;
      check_idle("in_reset");
      rsp_en = 1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      n = 0;
      while (resp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_idle("post_reset");
      resp_q.delete();

      // Clean random frame after the reset.
      wr_mode = 2; rdy_mode = 2;
      start_frame(29'($urandom));
      finish_frame("random", 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
